// File: rtl/uncache_axi_bridge_pkg.sv
// rtl/uncache_axi_bridge_pkg.sv - shared states, AXI constants and size helper for the uncache bridge
package uncache_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [3:0] AXI_ID_ZERO    = 4'd0;

    // Irregular lane patterns fall back to a full-width beat; strobes still mask bytes.
    function automatic logic [2:0] size_from_wsel(input logic [7:0] wsel);
        logic [3:0] ones;
        logic [2:0] size;
        ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'd0, wsel[i]};
        end
        case (ones)
            4'd1:    size = 3'd0;
            4'd2:    size = 3'd1;
            4'd4:    size = 3'd2;
            default: size = 3'd3;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/uncache_axi_bridge_if.sv
// rtl/uncache_axi_bridge_if.sv - single-beat AXI4 bus between uncache bridge (master) and memory/MMIO (slave)
interface uncache_axi_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic [7:0]        awlen;
    logic [1:0]        awburst;
    logic [3:0]        awid;

    logic              wvalid;
    logic              wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic [3:0]        arid;

    logic              rvalid;
    logic              rready;
    logic [63:0]       axi_rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output awvalid, awaddr, awsize, awlen, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arsize, arlen, arburst, arid,
        input  arready,
        input  rvalid, axi_rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awsize, awlen, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arsize, arlen, arburst, arid,
        output arready,
        output rvalid, axi_rdata, rresp, rlast,
        input  rready
    );

endinterface

// File: rtl/uncache_axi_size_enc.sv
// rtl/uncache_axi_size_enc.sv - combinational byte-lane select to AXI axsize encoder
module uncache_axi_size_enc
    import uncache_axi_bridge_pkg::*;
(
    input  logic [7:0] wsel,
    output logic [2:0] size
);

    always_comb begin
        size = size_from_wsel(wsel);
    end

endmodule

// File: rtl/uncache_axi_bridge.sv
// rtl/uncache_axi_bridge.sv - one-outstanding uncached load/store to single-beat AXI4; watchdog via UNCACHE_BRIDGE_TIMEOUT_EN
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_e,
    input  logic                req_we,
    input  logic [63:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [7:0]          req_wsel,
    output logic                req_ready,

    output logic                refresh,
    output logic [DATA_W-1:0]   rdata,
    output logic                resp_err,

    uncache_axi_bridge_if.master axi
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_wdata;
    logic [7:0]          hold_wsel;
    logic [2:0]          hold_size;
    logic                aw_done, w_done;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                timeout_hit;
    logic                unused_in;

    assign unused_in = ^{req_addr[63:ADDR_W], axi.rlast, axi.rresp[0], axi.bresp[0]};

    uncache_axi_size_enc u_size_enc (
        .wsel (hold_wsel),
        .size (hold_size)
    );

`ifdef UNCACHE_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q;

    // Any state change restarts the watchdog, so it bounds each wait individually.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE || state_d != state_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE:    if (req_e) state_d = req_we ? ST_WR : ST_RD;
            ST_RD:      if (axi.arready) state_d = ST_RD_DATA;
            ST_RD_DATA: if (axi.rvalid) state_d = ST_DONE;
            ST_WR: begin
                if ((aw_done || axi.awready) && (w_done || axi.wready)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (axi.bvalid) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
`ifdef UNCACHE_BRIDGE_TIMEOUT_EN
        if (state_q != ST_IDLE && state_q != ST_DONE &&
            cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout_hit = 1'b1;
            state_d     = ST_DONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wsel  <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_e) begin
                hold_addr  <= req_addr[ADDR_W-1:0];
                hold_wdata <= req_wdata;
                hold_wsel  <= req_wsel;
            end
            if (state_q == ST_WR) begin
                if (axi.awvalid && axi.awready) aw_done <= 1'b1;
                if (axi.wvalid && axi.wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (state_q == ST_RD_DATA && axi.rvalid) begin
                rdata_q <= axi.axi_rdata;
                err_q   <= axi.rresp[1];
            end else if (state_q == ST_WR_RESP && axi.bvalid) begin
                err_q   <= axi.bresp[1];
            end
        end
    end

    // Valids decode only registered state so they never follow the readys combinationally.
    always_comb begin
        axi.awvalid = (state_q == ST_WR) && !aw_done;
        axi.wvalid  = (state_q == ST_WR) && !w_done;
        axi.bready  = (state_q == ST_WR_RESP);
        axi.arvalid = (state_q == ST_RD);
        axi.rready  = (state_q == ST_RD_DATA);
        axi.awaddr  = hold_addr;
        axi.araddr  = hold_addr;
        axi.awsize  = hold_size;
        axi.arsize  = hold_size;
        axi.awlen   = AXI_LEN_SINGLE;
        axi.arlen   = AXI_LEN_SINGLE;
        axi.awburst = BURST_INCR;
        axi.arburst = BURST_INCR;
        axi.awid    = AXI_ID_ZERO;
        axi.arid    = AXI_ID_ZERO;
        axi.wdata   = hold_wdata;
        axi.wstrb   = hold_wsel;
        axi.wlast   = 1'b1;
    end

    assign req_ready = (state_q == ST_IDLE);
    assign refresh   = (state_q == ST_DONE);
    assign rdata     = rdata_q;
    assign resp_err  = err_q;

endmodule
